instr_loader: RTL

Program loader that writes machine code into instruction memory before the core runs. It accepts a little-endian byte stream over a valid/ready handshake and packs each group of four bytes into one 32-bit instruction. It issues one write per instruction to the instruction memory write port at consecutive word-aligned byte addresses, and holds the fetch stage's PC in reset until the load completes. It is the writer side of the instruction memory that fetch reads.

---
 rtl/instr_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
//==============================================================================
// Module      : instr_loader
// Description : Packs a little-endian byte stream into 32-bit instructions and
//               writes them to instruction memory, holding the core until done.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module instr_loader #(
  parameter int SIZE = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  input  logic                         byte_last,
  output logic                         byte_ready,
  output logic                         wr_en,
  output logic [`WORD-1:0]             wr_addr,
  output logic [`INSTR_LEN-1:0]        wr_data,
  output logic [$clog2(SIZE+1)-1:0]    word_count,
  output logic                         cpu_hold,
  output logic                         load_done,
  output logic                         error
);

  localparam int CW = $clog2(SIZE+1);
  localparam int AW = `WORD;
  localparam int DW = `INSTR_LEN;
  localparam logic [CW-1:0] c_size = CW'(SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_lane;
  logic [23:0]     r_buf;
  logic [DW-1:0]   r_wr_data;
  logic [AW-1:0]   r_wr_addr;
  logic [CW-1:0]   r_word_count;
  logic            r_last;
  logic            w_accept;
  logic            w_restart;
  logic [CW-1:0]   w_count_inc;

  assign w_count_inc = r_word_count + CW'(1);
  assign w_accept    = byte_valid && (r_state == S_LOAD);
  assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERR));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        if (w_accept) begin
          if (r_lane == 2'd3) begin
            w_next = S_WRITE;
          end else if (byte_last) begin
            w_next = S_ERR;
          end
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        if (r_last || (w_count_inc == c_size)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) w_next = S_LOAD;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte lanes, assembled word, write address and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lane       <= 2'd0;
      r_buf        <= 24'd0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_last       <= 1'b0;
    end else if (w_restart) begin
      r_lane       <= 2'd0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_last       <= 1'b0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0: r_buf[7:0]   <= byte_in;
        2'd1: r_buf[15:8]  <= byte_in;
        2'd2: r_buf[23:16] <= byte_in;
        default: begin
          r_wr_data <= DW'({byte_in, r_buf});
          r_wr_addr <= AW'({r_word_count, 2'b00});
          r_last    <= byte_last;
        end
      endcase
    end else if (r_state == S_WRITE) begin
      r_word_count <= w_count_inc;
      r_lane       <= 2'd0;
    end
  end

  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;

endmodule

`default_nettype wire
